// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared definitions for the Common Data Bus: default widths, broadcast record,
// functional-unit source indices and a small wrap-around helper.
package cdb_pkg;

    localparam int CDB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
    } cdb_bcast_t;

    localparam int SRC_ALU    = 0;
    localparam int SRC_BRANCH = 1;
    localparam int SRC_LSU    = 2;
    localparam int SRC_MUL    = 3;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_src_fifo.sv
// Per-source result buffer: decouples a functional unit from CDB arbitration.
// Depth need not be a power of two; flush empties it and discards that cycle's push/pop.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_value,
    output logic              empty,
    output logic              full
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [TAG_W-1:0]  tag_mem   [BUF_DEPTH];
    logic [DATA_W-1:0] value_mem [BUF_DEPTH];
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(BUF_DEPTH));
    // A full buffer refuses a push even when it is being popped this cycle.
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign head_tag   = tag_mem[rd_ptr];
    assign head_value = value_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            tag_mem[wr_ptr]   <= push_tag;
            value_mem[wr_ptr] <= push_value;
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common Data Bus arbiter: buffers results from NUM_SRC functional units, grants one
// non-empty buffer per cycle (round-robin or fixed priority) and registers the broadcast.
module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W,
    parameter int BUF_DEPTH = 2,
    parameter int ARB_MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]  src_value,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_value,
    output logic [$clog2(NUM_SRC)-1:0] cdb_src
);

    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] pop;
    logic [TAG_W-1:0]   head_tag   [NUM_SRC];
    logic [DATA_W-1:0]  head_value [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_ready[i] = !full[i];
        assign req[i]       = !empty[i];
        assign pop[i]       = grant && (grant_idx == SRC_W'(i));

        cdb_src_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .TAG_W     (TAG_W),
            .DATA_W    (DATA_W)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .push       (src_valid[i] && !full[i]),
            .push_tag   (src_tag[i*TAG_W +: TAG_W]),
            .push_value (src_value[i*DATA_W +: DATA_W]),
            .pop        (pop[i]),
            .head_tag   (head_tag[i]),
            .head_value (head_value[i]),
            .empty      (empty[i]),
            .full       (full[i])
        );
    end

    // Arbitration looks only at buffered entries, never at same-cycle src_valid,
    // so a fresh result always spends at least one cycle in its buffer.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_w;
        grant     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            if (ARB_MODE == 0)
                idx = (int'(rr_ptr) + off) % NUM_SRC;
            else
                idx = off;
            idx_w = SRC_W'(idx);
            if (!grant && req[idx_w]) begin
                grant     = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    // Broadcast register stage; payload holds its last value when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= grant;
            if (grant) begin
                cdb_tag   <= head_tag[grant_idx];
                cdb_value <= head_value[grant_idx];
                cdb_src   <= grant_idx;
                if (ARB_MODE == 0)
                    rr_ptr <= SRC_W'(wrap_inc(int'(grant_idx), NUM_SRC));
            end
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter: a round-robin instance and a fixed-priority
// instance, vector table for latency/ordering plus hand-written multi-cycle sequences.
module tb_cdb_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;

    logic [3:0]   rr_valid, rr_ready;
    logic [19:0]  rr_tag;
    logic [127:0] rr_value;
    logic         rr_cdb_valid;
    logic [4:0]   rr_cdb_tag;
    logic [31:0]  rr_cdb_value;
    logic [1:0]   rr_cdb_src;

    logic [3:0]   fp_valid, fp_ready;
    logic [19:0]  fp_tag;
    logic [127:0] fp_value;
    logic         fp_cdb_valid;
    logic [4:0]   fp_cdb_tag;
    logic [31:0]  fp_cdb_value;
    logic [1:0]   fp_cdb_src;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cdb_rr_arbiter #(.NUM_SRC(4), .TAG_W(5), .DATA_W(32), .BUF_DEPTH(2), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(rr_valid), .src_ready(rr_ready), .src_tag(rr_tag), .src_value(rr_value),
        .cdb_valid(rr_cdb_valid), .cdb_tag(rr_cdb_tag), .cdb_value(rr_cdb_value), .cdb_src(rr_cdb_src)
    );

    cdb_rr_arbiter #(.NUM_SRC(4), .TAG_W(5), .DATA_W(32), .BUF_DEPTH(2), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(fp_valid), .src_ready(fp_ready), .src_tag(fp_tag), .src_value(fp_value),
        .cdb_valid(fp_cdb_valid), .cdb_tag(fp_cdb_tag), .cdb_value(fp_cdb_value), .cdb_src(fp_cdb_src)
    );

    typedef struct packed {
        logic            fl;
        logic [3:0]      valid;
        logic [3:0][4:0] tags;
        logic            ev;
        logic [4:0]      et;
        logic [1:0]      es;
    } vec_t;

    // Value carried with each tag; tag 7 maps to 0xAAAA0001.
    function automatic logic [31:0] vof(input logic [4:0] t);
        return {16'hAAAA, 11'b0, t ^ 5'd6};
    endfunction

    function automatic logic [31:0] exp_value(input logic [4:0] t);
        return (t == 5'd0) ? 32'd0 : vof(t);
    endfunction

    function automatic vec_t mk(input int fl, input int v, input int t3, input int t2,
                                input int t1, input int t0, input int ev, input int et, input int es);
        vec_t r;
        r.fl    = 1'(fl);
        r.valid = 4'(v);
        r.tags  = {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
        r.ev    = 1'(ev);
        r.et    = 5'(et);
        r.es    = 2'(es);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rr(input logic [3:0] v, input logic [19:0] t);
        rr_valid = v;
        rr_tag   = t;
        for (int i = 0; i < 4; i++)
            rr_value[i*32 +: 32] = vof(t[i*5 +: 5]);
    endtask

    task automatic drive_fp(input logic [3:0] v, input logic [19:0] t);
        fp_valid = v;
        fp_tag   = t;
        for (int i = 0; i < 4; i++)
            fp_value[i*32 +: 32] = vof(t[i*5 +: 5]);
    endtask

    task automatic chk_rr(input string name, input logic v, input logic [4:0] t, input logic [1:0] s);
        chk({name, " valid"}, 64'(rr_cdb_valid), 64'(v));
        chk({name, " tag"},   64'(rr_cdb_tag),   64'(t));
        chk({name, " value"}, 64'(rr_cdb_value), 64'(exp_value(t)));
        chk({name, " src"},   64'(rr_cdb_src),   64'(s));
    endtask

    task automatic chk_fp(input string name, input logic v, input logic [4:0] t, input logic [1:0] s);
        chk({name, " valid"}, 64'(fp_cdb_valid), 64'(v));
        chk({name, " tag"},   64'(fp_cdb_tag),   64'(t));
        chk({name, " value"}, 64'(fp_cdb_value), 64'(exp_value(t)));
        chk({name, " src"},   64'(fp_cdb_src),   64'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [18];
        logic [4:0] q [4][$];
        int         occ [4];
        logic [1:0] saw_low;
        logic [4:0] tagc1, tagc2;
        logic [3:0] acc;

        // latency on src 2, then RR order from ptr 0 and from ptr 2
        vecs[0]  = mk(0, 4'b0100,  0,  7,  0,  0,  0,  0, 0);
        vecs[1]  = mk(0, 4'b0000,  0,  0,  0,  0,  1,  7, 2);
        vecs[2]  = mk(0, 4'b0000,  0,  0,  0,  0,  0,  7, 2);
        vecs[3]  = mk(1, 4'b0000,  0,  0,  0,  0,  0,  7, 2);
        vecs[4]  = mk(0, 4'b1111,  4,  3,  2,  1,  0,  7, 2);
        vecs[5]  = mk(0, 4'b0000,  0,  0,  0,  0,  1,  1, 0);
        vecs[6]  = mk(0, 4'b0000,  0,  0,  0,  0,  1,  2, 1);
        vecs[7]  = mk(0, 4'b0000,  0,  0,  0,  0,  1,  3, 2);
        vecs[8]  = mk(0, 4'b0000,  0,  0,  0,  0,  1,  4, 3);
        vecs[9]  = mk(0, 4'b0000,  0,  0,  0,  0,  0,  4, 3);
        vecs[10] = mk(0, 4'b0010,  0,  0,  5,  0,  0,  4, 3);
        vecs[11] = mk(0, 4'b0000,  0,  0,  0,  0,  1,  5, 1);
        vecs[12] = mk(0, 4'b1111, 14, 13, 12, 11,  0,  5, 1);
        vecs[13] = mk(0, 4'b0000,  0,  0,  0,  0,  1, 13, 2);
        vecs[14] = mk(0, 4'b0000,  0,  0,  0,  0,  1, 14, 3);
        vecs[15] = mk(0, 4'b0000,  0,  0,  0,  0,  1, 11, 0);
        vecs[16] = mk(0, 4'b0000,  0,  0,  0,  0,  1, 12, 1);
        vecs[17] = mk(0, 4'b0000,  0,  0,  0,  0,  0, 12, 1);

        rst   = 1'b1;
        flush = 1'b0;
        drive_rr(4'b0, 20'b0);
        drive_fp(4'b0, 20'b0);
        tick();
        tick();
        rst = 1'b0;
        chk_rr("reset rr", 1'b0, 5'd0, 2'd0);
        chk_fp("reset fp", 1'b0, 5'd0, 2'd0);
        chk("reset rr ready", 64'(rr_ready), 64'hF);
        chk("reset fp ready", 64'(fp_ready), 64'hF);

        for (int r = 0; r < 18; r++) begin
            flush = vecs[r].fl;
            drive_rr(vecs[r].valid, vecs[r].tags);
            tick();
            chk_rr($sformatf("vec%0d", r), vecs[r].ev, vecs[r].et, vecs[r].es);
        end
        flush = 1'b0;
        drive_rr(4'b0, 20'b0);

        // backpressure: src 1 and 2 push every cycle, scoreboard per source
        for (int i = 0; i < 4; i++) occ[i] = 0;
        saw_low = 2'b00;
        tagc1   = 5'd1;
        tagc2   = 5'd17;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 12)
                drive_rr(4'b0110, {5'd0, tagc2, tagc1, 5'd0});
            else
                drive_rr(4'b0000, 20'b0);
            acc = rr_valid & rr_ready;
            if (acc[1]) begin q[1].push_back(tagc1); tagc1 = tagc1 + 5'd1; end
            if (acc[2]) begin q[2].push_back(tagc2); tagc2 = tagc2 + 5'd1; end
            tick();
            occ[1] += int'(acc[1]);
            occ[2] += int'(acc[2]);
            if (rr_cdb_valid) begin
                if (q[rr_cdb_src].size() == 0) begin
                    chk($sformatf("bp cyc%0d unexpected src", cyc), 64'(rr_cdb_src), 64'hFF);
                end else begin
                    chk($sformatf("bp cyc%0d tag", cyc), 64'(rr_cdb_tag), 64'(q[rr_cdb_src].pop_front()));
                    occ[rr_cdb_src]--;
                end
            end
            chk($sformatf("bp cyc%0d ready1", cyc), 64'(rr_ready[1]), 64'(occ[1] < 2));
            chk($sformatf("bp cyc%0d ready2", cyc), 64'(rr_ready[2]), 64'(occ[2] < 2));
            if (!rr_ready[1]) saw_low[0] = 1'b1;
            if (!rr_ready[2]) saw_low[1] = 1'b1;
        end
        chk("bp ready dropped", 64'(saw_low), 64'h3);
        chk("bp src1 drained", 64'(q[1].size()), 64'd0);
        chk("bp src2 drained", 64'(q[2].size()), 64'd0);

        // fixed priority: src 0 keeps src 3 waiting
        drive_fp(4'b1001, {5'd9, 5'd0, 5'd0, 5'd20});
        tick();
        chk_fp("fp e0", 1'b0, 5'd0, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            drive_fp(4'b0001, {15'd0, 5'(20 + k)});
            tick();
            chk_fp($sformatf("fp e%0d", k), 1'b1, 5'(19 + k), 2'd0);
        end
        drive_fp(4'b0000, 20'b0);
        tick();
        chk_fp("fp e5", 1'b1, 5'd24, 2'd0);
        tick();
        chk_fp("fp e6", 1'b1, 5'd9, 2'd3);
        tick();
        chk("fp e7 valid", 64'(fp_cdb_valid), 64'd0);

        // flush with three results buffered and a concurrent src 0 push
        drive_rr(4'b1111, {5'd23, 5'd22, 5'd21, 5'd20});
        tick();
        drive_rr(4'b0000, 20'b0);
        tick();
        chk("fl pre valid", 64'(rr_cdb_valid), 64'd1);
        flush = 1'b1;
        drive_rr(4'b0001, {15'd0, 5'd12});
        tick();
        flush = 1'b0;
        drive_rr(4'b0000, 20'b0);
        chk("fl valid", 64'(rr_cdb_valid), 64'd0);
        chk("fl ready", 64'(rr_ready), 64'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl idle%0d valid", k), 64'(rr_cdb_valid), 64'd0);
        end
        drive_rr(4'b1111, {5'd27, 5'd26, 5'd25, 5'd24});
        tick();
        drive_rr(4'b0000, 20'b0);
        chk("fl refill valid", 64'(rr_cdb_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_rr($sformatf("fl order%0d", k), 1'b1, 5'(24 + k), 2'(k));
        end

        // asynchronous reset with two results still buffered
        drive_rr(4'b1011, {5'd23, 5'd0, 5'd22, 5'd21});
        tick();
        drive_rr(4'b0000, 20'b0);
        tick();
        chk_rr("rst pre", 1'b1, 5'd21, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_rr("rst async", 1'b0, 5'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst ready", 64'(rr_ready), 64'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst idle%0d valid", k), 64'(rr_cdb_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Parametrised Common Data Bus arbiter and broadcaster for the Tomasulo core.
- Accepts completed results from NUM_SRC functional units (ALU, branch, LSU, MUL, …) through per-source valid/ready handshakes.
- Buffers each source's results in a small FIFO, so a unit losing arbitration does not stall its pipeline until its buffer fills.
- Each cycle it grants one non-empty source (round-robin or fixed priority) and drives a registered broadcast to the reservation stations, ROB and register file.

Parameters:
- NUM_SRC, 4, number of requesting functional units (≥2).
- TAG_W, 5, width of ROB/RS tag.
- DATA_W, 32, width of result value.
- BUF_DEPTH, 2, entries per source FIFO (≥1; need not be a power of two).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous mispredict flush; discards buffered and in-flight results.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source buffer-not-full.
- src_tag  in  NUM_SRC*TAG_W  packed tags; source i occupies bits [i*TAG_W +: TAG_W].
- src_value  in  NUM_SRC*DATA_W  packed values; same packing as src_tag.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast tag (registered).
- cdb_value  out  DATA_W  broadcast value (registered).
- cdb_src  out  $clog2(NUM_SRC)  index of the winning source (registered; debug and perf counters).

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs empty.
  - RR pointer = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_src = 0.
  - src_ready = all ones once rst is low.
  - Reset mid-operation drops all buffered results without broadcasting them.
- src_ready[i] = !full[i]; it depends only on state, never on the current grant.
- Push occurs when src_valid[i] && src_ready[i]. A full FIFO never accepts, even while popping that same cycle.
- FIFO internals:
  - Occupancy counter is $clog2(BUF_DEPTH+1) bits wide.
  - Read/write pointers wrap modulo BUF_DEPTH.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Arbitration (combinational, each cycle):
  - Request vector req[i] = !empty[i]. Arbitration never sees same-cycle src_valid.
  - ARB_MODE = 0: the first requesting index starting at rr_ptr, wrapping modulo NUM_SRC, wins. After a grant to i, rr_ptr ← (i+1) mod NUM_SRC. rr_ptr is unchanged when there is no grant.
  - ARB_MODE = 1: the lowest requesting index wins; rr_ptr is unused.
  - The winner's FIFO head is popped in the same cycle as the grant.
- Output register: on each edge, cdb_valid ← |req. When a grant occurs, cdb_tag, cdb_value and cdb_src are loaded from the winner's head. Otherwise they hold their previous values.
- Latency and throughput:
  - A result pushed at edge N is broadcast, at the earliest, with cdb_valid high after edge N+1 (2-cycle minimum).
  - One broadcast per cycle; each accepted result is broadcast exactly once.
- Fairness: in RR mode, with K sources continuously non-empty, each wins exactly once every K cycles.
- Flush:
  - flush high at edge N empties all FIFOs, sets cdb_valid ← 0 and rr_ptr ← 0.
  - Pushes and pops in that cycle are discarded.
  - flush has priority over push, pop and grant.

Decomposition:
- Shared package cdb_pkg holds:
  - TAG_W and DATA_W defaults.
  - typedef cdb_bcast_t {valid, tag, value}.
  - Source-index constants SRC_ALU = 0, SRC_BRANCH = 1, SRC_LSU = 2, SRC_MUL = 3.
- Natural sub-module: cdb_src_fifo (parametrised BUF_DEPTH/TAG_W/DATA_W, with flush), instantiated NUM_SRC times via generate. Arbiter and output register stay in the top module.

Test Plan:
1. Reset and idle: assert rst mid-stream with 2 results buffered → cdb_valid = 0 immediately; src_ready = 4'b1111 after release; no stale broadcast follows.
2. Single source, latency: push tag 7 / value 0xAAAA0001 on src 2 at edge 10 → cdb_valid = 1, cdb_tag = 7, cdb_value = 0xAAAA0001, cdb_src = 2 after edge 11, and low after edge 12.
3. Round-robin fairness (ARB_MODE = 0): all 4 sources push tags 1, 2, 3, 4 in the same cycle → broadcast order src 0, 1, 2, 3 on 4 consecutive cycles. A second burst with rr_ptr = 2 yields order 2, 3, 0, 1.
4. Fixed priority (ARB_MODE = 1): src 0 pushes every cycle and src 3 holds tag 9 → src 3 is never granted while src 0 is non-empty; tag 9 is broadcast in the first cycle src 0's FIFO is empty.
5. Backpressure (BUF_DEPTH = 2): src 1 and src 2 push every cycle in RR mode → each src_ready drops after its FIFO holds 2 entries. No result is lost or duplicated: the scoreboard compares the accepted tag sequence per source with the broadcast sequence.
6. Flush: 3 results buffered and cdb_valid high; assert flush together with a src 0 push of tag 12 → cdb_valid = 0 next cycle, all FIFOs empty, tag 12 never broadcast, rr_ptr = 0.
